// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter family.
package dmem_port_arbiter_pkg;

    // Ownership of the shared memory port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Requester indices; also the encoding of the last-winner register.
    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    // Legal range of the lock hold limit and the width of its wait counter.
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 255;
    localparam int WAIT_CNT_W   = 8;

    // Forces an out-of-range hold limit back into the range the 8-bit counter can express.
    function automatic int clampHold(input int hold);
        if (hold < MAX_HOLD_MIN) begin
            return MAX_HOLD_MIN;
        end else if (hold > MAX_HOLD_MAX) begin
            return MAX_HOLD_MAX;
        end else begin
            return hold;
        end
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter: counts cycles a non-owner has been kept waiting.
// The limit output rises once LIMIT-1 cycles have been counted, telling the
// arbiter that any lock must now be broken.
module arb_starve_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int WIDTH = WAIT_CNT_W,
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic limit
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    // Clear has priority; counting stops once the top value is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != TOP)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign limit = (r_count == TOP);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port. Round-robin between
// the load/store path (port 0) and a secondary master (port 1), with an
// optional ownership lock that is bounded by a starvation limit. Grants are
// decoded from the registered owner state, so a port that already owns the
// memory is served in the same cycle it requests.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int HOLD_LIMIT = clampHold(MAX_HOLD);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic              r_last;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_otherReq;
    logic              w_waitLimit;
    logic              w_waitClr;
    logic              w_waitEn;

    assign w_gnt0 = (r_state == ST_OWN0) && req0;
    assign w_gnt1 = (r_state == ST_OWN1) && req1;

    // Route the owner's address and store data to the memory; nothing is driven while idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_OWN0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
            ST_OWN1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

    assign mem_we = (w_gnt0 && we0) || (w_gnt1 && we1);
    assign mem_re = (w_gnt0 && !we0) || (w_gnt1 && !we1);

    // Pick next cycle's owner: a lock holds unless the waiter hit its limit, otherwise alternate.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_nextState = (r_last == 1'(PORT1)) ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    w_nextState = ST_OWN0;
                end else if (req1) begin
                    w_nextState = ST_OWN1;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (req0 && lock0 && !(req1 && w_waitLimit)) begin
                    w_nextState = ST_OWN0;
                end else if (req1) begin
                    w_nextState = ST_OWN1;
                end else if (req0) begin
                    w_nextState = ST_OWN0;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (req1 && lock1 && !(req0 && w_waitLimit)) begin
                    w_nextState = ST_OWN1;
                end else if (req0) begin
                    w_nextState = ST_OWN0;
                end else if (req1) begin
                    w_nextState = ST_OWN1;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // The waiter is whichever port does not own the memory; the owner never blocks itself.
    always_comb begin
        w_otherReq = 1'b0;
        case (r_state)
            ST_OWN0: w_otherReq = req1;
            ST_OWN1: w_otherReq = req0;
            default: w_otherReq = 1'b0;
        endcase
    end

    assign w_waitClr = (r_state == ST_IDLE) || (w_nextState != r_state) || !w_otherReq;
    assign w_waitEn  = !w_waitClr;

    arb_starve_counter #(
        .WIDTH (WAIT_CNT_W),
        .LIMIT (HOLD_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (w_waitClr),
        .en    (w_waitEn),
        .limit (w_waitLimit)
    );

    // Owner state and last winner; last starts at port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'(PORT1);
        end else begin
            r_state <= w_nextState;
            if (w_gnt0) begin
                r_last <= 1'(PORT0);
            end else if (w_gnt1) begin
                r_last <= 1'(PORT1);
            end
        end
    end

    // Capture load data one cycle after a load grant; rdata holds between loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 && !we0;
            r_rvalid1 <= w_gnt1 && !we1;
            if (mem_re) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter. The stimulus side keeps a small
// ownership model and a copy of memory, queues the access and read-return it
// expects for each cycle, and a separate monitor pops and compares whenever
// the arbiter grants or returns data.
module tb_dmem_port_arbiter;

    localparam int AW            = 64;
    localparam int DW            = 64;
    localparam int HOLD          = 4;
    localparam int RANDOM_CYCLES = 3000;

    typedef struct {
        int            cyc;
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } accItem_t;

    typedef struct {
        int            cyc;
        int            port;
        logic [DW-1:0] data;
    } rdItem_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_rdata;

    int            checks = 0;
    int            errors = 0;
    int            cycleNo = 0;
    accItem_t      accQ[$];
    rdItem_t       rdQ[$];
    accItem_t      ai;
    rdItem_t       ri;

    logic          memInit = 1'b1;
    logic [DW-1:0] memArr [16];
    logic [DW-1:0] refMem [16];

    logic          pReq [2];
    logic          pWe [2];
    logic          pLock [2];
    logic          pRenew [2];
    logic [AW-1:0] pAddr [2];
    logic [DW-1:0] pWdata [2];
    int            mOwner;
    int            mLast;
    int            mWaited;
    bit            randomMode = 1'b0;

    dmem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected grants and read returns.
    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Initial memory image: word 2 (byte address 0x10) holds 0xDEADBEEF.
    function automatic logic [DW-1:0] memPattern(input int i);
        if (i == 2) begin
            return 64'h0000_0000_DEAD_BEEF;
        end
        return {32'hC0DE_0000, 32'(i)};
    endfunction

    // Data memory: combinational read, store commits at the clock edge ending the grant cycle.
    assign mem_rdata = memArr[mem_addr[6:3]];
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 16; i++) memArr[i] <= memPattern(i);
        end else if (mem_we) begin
            memArr[mem_addr[6:3]] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycleNo, actual, expected);
        end
    endtask

    // Monitor: pop the expected item whenever the arbiter grants or returns load data.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("grant_onehot", 64'(gnt0 && gnt1), 64'd0);
            if (gnt0 || gnt1) begin
                checkOutput("grant_expected", 64'(accQ.size() > 0), 64'd1);
                if (accQ.size() > 0) begin
                    ai = accQ.pop_front();
                    checkOutput("grant_cycle", 64'(cycleNo), 64'(ai.cyc));
                    checkOutput("grant_port", 64'(gnt1), 64'(ai.port));
                    checkOutput("mem_we", 64'(mem_we), 64'(ai.we));
                    checkOutput("mem_re", 64'(mem_re), 64'(!ai.we));
                    checkOutput("mem_addr", mem_addr, ai.addr);
                    if (ai.we) checkOutput("mem_wdata", mem_wdata, ai.data);
                end
            end else begin
                checkOutput("idle_mem_we", 64'(mem_we), 64'd0);
                checkOutput("idle_mem_re", 64'(mem_re), 64'd0);
            end
            checkOutput("rvalid_onehot", 64'(rvalid0 && rvalid1), 64'd0);
            if (rvalid0 || rvalid1) begin
                checkOutput("rvalid_expected", 64'(rdQ.size() > 0), 64'd1);
                if (rdQ.size() > 0) begin
                    ri = rdQ.pop_front();
                    checkOutput("rvalid_cycle", 64'(cycleNo), 64'(ri.cyc));
                    checkOutput("rvalid_port", 64'(rvalid1), 64'(ri.port));
                    checkOutput("rdata", rdata, ri.data);
                end
            end
        end
    end

    task automatic setReq(input int p, input logic we, input logic lock, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic renew);
        pReq[p]   = 1'b1;
        pWe[p]    = we;
        pLock[p]  = lock;
        pAddr[p]  = addr;
        pWdata[p] = wdata;
        pRenew[p] = renew;
    endtask

    task automatic clearReqs();
        for (int p = 0; p < 2; p++) begin
            pReq[p]   = 1'b0;
            pLock[p]  = 1'b0;
            pRenew[p] = 1'b0;
        end
    endtask

    task automatic resetModel();
        mOwner  = -1;
        mLast   = 1;
        mWaited = 0;
        accQ.delete();
        rdQ.delete();
    endtask

    task automatic randomizeRequests();
        for (int p = 0; p < 2; p++) begin
            if (!pReq[p]) begin
                if ($urandom_range(0, 99) < 55) begin
                    setReq(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4),
                           64'($urandom_range(0, 15)) << 3, {$urandom, $urandom}, 1'b0);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                pReq[p] = 1'b0;
            end
        end
    endtask

    // Drive this cycle's requests, predict the access, then decide who owns the next cycle.
    task automatic applyStimulus();
        int g;
        int nxt;
        int x;
        int y;
        req0 = pReq[0]; we0 = pWe[0]; lock0 = pLock[0]; addr0 = pAddr[0]; wdata0 = pWdata[0];
        req1 = pReq[1]; we1 = pWe[1]; lock1 = pLock[1]; addr1 = pAddr[1]; wdata1 = pWdata[1];
        g = -1;
        if (mOwner >= 0 && pReq[mOwner]) g = mOwner;
        if (g >= 0) begin
            accQ.push_back('{cycleNo, g, pWe[g], pAddr[g], pWdata[g]});
            if (pWe[g]) refMem[pAddr[g][6:3]] = pWdata[g];
            else rdQ.push_back('{cycleNo + 1, g, refMem[pAddr[g][6:3]]});
            mLast = g;
        end
        if (mOwner < 0) begin
            if (pReq[0] && pReq[1]) nxt = 1 - mLast;
            else if (pReq[0]) nxt = 0;
            else if (pReq[1]) nxt = 1;
            else nxt = -1;
            mWaited = 0;
        end else begin
            x = mOwner;
            y = 1 - x;
            if (pReq[x] && pLock[x] && !(pReq[y] && mWaited == HOLD - 1)) nxt = x;
            else if (pReq[y]) nxt = y;
            else if (pReq[x]) nxt = x;
            else nxt = -1;
            if (nxt == x && pReq[y]) mWaited = (mWaited < HOLD - 1) ? mWaited + 1 : mWaited;
            else mWaited = 0;
        end
        mOwner = nxt;
        if (g >= 0 && !pRenew[g]) pReq[g] = 1'b0;
        if (randomMode) randomizeRequests();
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    endtask

    // Idle cycle, grant cycle, then read return checked against a known constant.
    task automatic loadAndCheck(input logic [AW-1:0] addr, input logic [DW-1:0] expected, input string name);
        setReq(0, 1'b0, 1'b0, addr, '0, 1'b0);
        runCycles(3);
        #2;
        checkOutput({name, "_rvalid0"}, 64'(rvalid0), 64'd1);
        checkOutput({name, "_rdata"}, rdata, expected);
        runCycles(2);
    endtask

    // Main stimulus sequence: directed cases first, then a randomised run.
    initial begin
        int run;
        int maxRun;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 16; i++) refMem[i] = memPattern(i);
        for (int p = 0; p < 2; p++) begin
            pWe[p] = 1'b0; pAddr[p] = '0; pWdata[p] = '0;
        end
        clearReqs();
        resetModel();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gnt0", 64'(gnt0), 64'd0);
        checkOutput("reset_gnt1", 64'(gnt1), 64'd0);
        checkOutput("reset_rvalid0", 64'(rvalid0), 64'd0);
        checkOutput("reset_rvalid1", 64'(rvalid1), 64'd0);
        checkOutput("reset_rdata", rdata, 64'd0);
        checkOutput("reset_mem_addr", mem_addr, 64'd0);
        checkOutput("reset_mem_strobes", {62'd0, mem_we, mem_re}, 64'd0);
        memInit = 1'b0;
        reset   = 1'b0;

        // Single load from 0x10.
        loadAndCheck(64'h10, 64'hDEAD_BEEF, "tp_load");

        // Tie without lock alternates every cycle.
        setReq(0, 1'b0, 1'b0, 64'h08, '0, 1'b1);
        setReq(1, 1'b0, 1'b0, 64'h30, '0, 1'b1);
        runCycles(9);
        clearReqs();
        runCycles(3);

        // Lock with starvation bound: port 0 locks, port 1 joins later.
        setReq(0, 1'b0, 1'b1, 64'h18, '0, 1'b1);
        runCycles(2);
        setReq(1, 1'b0, 1'b0, 64'h28, '0, 1'b1);
        run = 0;
        maxRun = 0;
        for (int c = 0; c < 14; c++) begin
            runCycles(1);
            #2;
            if (gnt0 && req1) run++;
            else run = 0;
            if (run > maxRun) maxRun = run;
        end
        checkOutput("tp_lock_maxrun", 64'(maxRun), 64'(HOLD));
        clearReqs();
        runCycles(3);

        // Store from port 1 then read it back through port 0.
        setReq(1, 1'b1, 1'b0, 64'h40, 64'h1234, 1'b0);
        runCycles(4);
        loadAndCheck(64'h40, 64'h1234, "tp_store");

        // Reset in the grant cycle of a port-1 load.
        setReq(1, 1'b0, 1'b0, 64'h18, '0, 1'b0);
        runCycles(2);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("tp_rst_gnt1", 64'(gnt1), 64'd0);
        checkOutput("tp_rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("tp_rst_mem_re", 64'(mem_re), 64'd0);
        checkOutput("tp_rst_rvalid1", 64'(rvalid1), 64'd0);
        checkOutput("tp_rst_rdata", rdata, 64'd0);
        clearReqs();
        resetModel();
        req0 = 0; req1 = 0;
        @(posedge clk);
        #1;
        checkOutput("tp_rst_no_rvalid1", 64'(rvalid1), 64'd0);
        reset = 1'b0;
        setReq(0, 1'b0, 1'b0, 64'h20, '0, 1'b0);
        setReq(1, 1'b0, 1'b0, 64'h38, '0, 1'b0);
        runCycles(2);
        #2;
        checkOutput("tp_rst_tie_gnt0", 64'(gnt0), 64'd1);
        runCycles(4);

        // Owner withdraws its request with the other port quiet.
        setReq(0, 1'b0, 1'b1, 64'h20, '0, 1'b1);
        runCycles(3);
        clearReqs();
        runCycles(1);
        #2;
        checkOutput("tp_withdraw_gnt0", 64'(gnt0), 64'd0);
        checkOutput("tp_withdraw_mem_re", 64'(mem_re), 64'd0);
        setReq(0, 1'b0, 1'b0, 64'h20, '0, 1'b0);
        runCycles(1);
        #2;
        checkOutput("tp_withdraw_idle", 64'(gnt0), 64'd0);
        runCycles(1);
        #2;
        checkOutput("tp_withdraw_regrant", 64'(gnt0), 64'd1);
        runCycles(3);

        // Randomised traffic against the model.
        randomMode = 1'b1;
        runCycles(RANDOM_CYCLES);
        randomMode = 1'b0;
        clearReqs();
        runCycles(4);
        #2;
        checkOutput("acc_queue_drained", 64'(accQ.size()), 64'd0);
        checkOutput("rd_queue_drained", 64'(rdQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter that shares the single 64-bit data memory port between the core load/store path (port 0) and a secondary master (port 1: program loader / debug / DMA). It sits between the requesters and the data memory, and serialises accesses one per cycle. Arbitration is round-robin, with an optional lock for back-to-back bursts and a starvation limit that bounds any lock. Granted reads are returned through a registered read-data path.

## Interface
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width.
- `MAX_HOLD`, 8: maximum consecutive cycles the other port may wait while a locked owner holds the memory; range 1–255.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req0` / `req1` in 1: access request; held with its payload until granted.
- `we0` / `we1` in 1: 1 = store, 0 = load.
- `lock0` / `lock1` in 1: request to keep ownership on the next cycle.
- `addr0` / `addr1` in ADDR_W: byte address.
- `wdata0` / `wdata1` in DATA_W: store data.
- `gnt0` / `gnt1` out 1: access performed this cycle.
- `rvalid0` / `rvalid1` out 1: read data valid, one cycle after a load grant.
- `rdata` out DATA_W: registered load data, shared by both ports.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_we` / `mem_re` out 1: memory write / read strobes.
- `mem_rdata` in DATA_W: combinational memory read data.

## Operation
- States: IDLE, OWN0, OWN1.
- Other registers:
  - `last`: last winner, reset 1, so port 0 wins the first tie.
  - `wait_cnt`: 8-bit, reset 0.
- Grant outputs: `gnt_x = (state == OWN_x) && req_x`.
  - Memory outputs mux the owner's addr/wdata.
  - `mem_we = gnt_x && we_x`; `mem_re = gnt_x && !we_x`.
  - In IDLE, all memory outputs are 0.
- Next state from IDLE:
  - Only one request → OWN of that port.
  - Both requests → OWN of the port that is not `last`.
  - No request → stay IDLE.
- Next state from OWN_x, with y the other port:
  - `req_x && lock_x && !(req_y && wait_cnt == MAX_HOLD-1)` → stay OWN_x.
  - Else `req_y` → OWN_y.
  - Else `req_x` → stay OWN_x.
  - Else → IDLE.
- `last` updates to x whenever `gnt_x` is 1.
- `wait_cnt`:
  - Increments while in OWN_x with `req_y` high and `gnt_y` low.
  - Clears on any state change and whenever `req_y` is low.
  - Saturates at MAX_HOLD-1.
- Without lock, contention alternates every cycle: 0,1,0,1.
- Read return: on the edge after a load grant, register `rdata <= mem_rdata` and pulse `rvalid_x = 1` for one cycle. Otherwise `rdata` holds its value and `rvalid` stays 0.
- Requester drops `req` while its port is the owner: no access that cycle; FSM proceeds per the rules above.
- Stores produce no `rvalid`.

## Timing
- Registered grant state: a request rising in cycle N sees `gnt` at the earliest in cycle N+1 from IDLE.
- A request arriving while its port already owns the memory is granted in the same cycle.
- A store commits at the memory's clock edge at the end of the grant cycle.
- Load data arrives on `rdata` in the grant cycle +1.
- Throughput: one access per cycle. No bubble on an owner switch under contention.
- Worst-case wait for a non-owner while the other port holds a lock: MAX_HOLD cycles.
- Reset values: state IDLE, `last` 1, `wait_cnt` 0, `gnt*` 0, `rvalid*` 0, `rdata` 0, all `mem_*` 0.
- Reset mid-access drops the access: no write is issued, and no `rvalid` follows.

## Structure
- Shared package holds:
  - The state enum (IDLE / OWN0 / OWN1).
  - Port index constants.
  - The MAX_HOLD range limit.
- One sub-module, `arb_starve_counter`: the saturating `wait_cnt` with clear/enable and a `limit` output. Reused by future multi-port arbiters.
- Payload mux and read return are inline.

## Test plan
- Single load: reset; `req0` with addr 0x10, memory word 0xDEADBEEF → `gnt0` in cycle 1, `mem_re` 1, `rvalid0` with `rdata` 0xDEADBEEF in cycle 2.
- Tie and round-robin: `req0` and `req1` both held, no lock → `gnt0`, `gnt1`, `gnt0`, `gnt1` on successive cycles, no idle cycle between.
- Lock with starvation: `req0` + `lock0` held, `req1` raised, MAX_HOLD=4 → `gnt0` for 4 cycles, then `gnt1` on the next cycle.
- Store path: `req1` with `we1`, addr 0x40, wdata 0x1234 → `mem_we` 1 for one cycle, no `rvalid1`; a later load from 0x40 returns 0x1234.
- Reset mid-operation: assert `reset` in the OWN1 grant cycle of a load → `gnt1`, `mem_we`, `mem_re`, `rvalid1` all 0 immediately; `rdata` 0; next tie after release goes to port 0.
- Request withdrawal: port 0 owns; it drops `req0` while `req1` is low → `gnt0` 0, no memory access; FSM returns to IDLE.
